// File: rtl/sm_add_pipe.sv
// Two-stage pipelined sign-magnitude adder with valid/ready on both sides.
// Stage 1 registers the operands already ordered by magnitude (big/small)
// together with the effective operation. Stage 2 runs a ripple-carry add or
// subtract, resolves the sign, forces -0 to +0 and flags magnitude overflow.
// Optional build macro SM_ADD_SAT_EN: saturate the magnitude on add overflow
// instead of wrapping it.
module sm_add_pipe #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         ovf
);

  localparam int unsigned M = N - 1;  // magnitude width

  logic         s1_valid_q, s1_valid_d;
  logic [M-1:0] s1_big_q, s1_big_d;
  logic [M-1:0] s1_small_q, s1_small_d;
  logic         s1_sign_q, s1_sign_d;
  logic         s1_sub_q, s1_sub_d;

  logic         s2_valid_q, s2_valid_d;
  logic [N-1:0] s2_sum_q, s2_sum_d;
  logic         s2_ovf_q, s2_ovf_d;

  logic         s2_adv;
  logic         in_fire;

  logic [M-1:0] rca_b;
  logic [M-1:0] rca_sum;
  logic [M:0]   carry;
  logic         add_ovf;
  logic [M-1:0] mag_res;

  // Stage 2 can take new data when empty or when its result is being consumed.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 next state: order operands by magnitude; ties keep A as the larger.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_big_d   = s1_big_q;
    s1_small_d = s1_small_q;
    s1_sign_d  = s1_sign_q;
    s1_sub_d   = s1_sub_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_sub_d   = a[N-1] ^ b[N-1];
      if (b[M-1:0] > a[M-1:0]) begin
        s1_big_d   = b[M-1:0];
        s1_small_d = a[M-1:0];
        s1_sign_d  = b[N-1];
      end else begin
        s1_big_d   = a[M-1:0];
        s1_small_d = b[M-1:0];
        s1_sign_d  = a[N-1];
      end
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Ripple-carry datapath; subtract is big + ~small + 1, which never goes
  // negative because big >= small.
  always_comb begin
    rca_b    = s1_sub_q ? ~s1_small_q : s1_small_q;
    carry    = '0;
    carry[0] = s1_sub_q;
    rca_sum  = '0;
    for (int i = 0; i < int'(M); i++) begin
      rca_sum[i]   = s1_big_q[i] ^ rca_b[i] ^ carry[i];
      carry[i+1]   = (s1_big_q[i] & rca_b[i]) | (carry[i] & (s1_big_q[i] ^ rca_b[i]));
    end
  end

  // Overflow only exists on the add path; the subtract carry-out is discarded.
  always_comb begin
    add_ovf = !s1_sub_q && carry[M];
`ifdef SM_ADD_SAT_EN
    mag_res = add_ovf ? '1 : rca_sum;
`else
    mag_res = rca_sum;
`endif
  end

  // Stage 2 next state: load the result and force the sign of a zero magnitude to +.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    s2_ovf_d   = s2_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_d = {(mag_res != '0) && s1_sign_q, mag_res};
        s2_ovf_d = add_ovf;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_big_q   <= '0;
      s1_small_q <= '0;
      s1_sign_q  <= 1'b0;
      s1_sub_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_ovf_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_big_q   <= s1_big_d;
      s1_small_q <= s1_small_d;
      s1_sign_q  <= s1_sign_d;
      s1_sub_q   <= s1_sub_d;
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
      s2_ovf_q   <= s2_ovf_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign s         = s2_sum_q;
  assign ovf       = s2_ovf_q;

endmodule

// File: tb/tb_sm_add_pipe.sv
// Self-checking bench for sm_add_pipe at N=4 (sign + 3-bit magnitude).
// Expected results come from an arithmetic sign-magnitude model; honours
// SM_ADD_SAT_EN the same way the design build does.
module tb_sm_add_pipe;

  localparam int N    = 4;
  localparam int M    = N - 1;
  localparam int MAXM = (1 << M) - 1;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  sm_add_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {ovf, s} from plain integer sign-magnitude arithmetic.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    int mx, my, sum, mag;
    logic sg, ov;
    logic [M-1:0] mm;
    mx = int'(x[M-1:0]);
    my = int'(y[M-1:0]);
    ov = 1'b0;
    if (x[N-1] == y[N-1]) begin
      sum = mx + my;
      sg  = x[N-1];
      if (sum > MAXM) begin
        ov = 1'b1;
`ifdef SM_ADD_SAT_EN
        mag = MAXM;
`else
        mag = sum - (MAXM + 1);
`endif
      end else begin
        mag = sum;
      end
    end else if (my > mx) begin
      mag = my - mx;
      sg  = y[N-1];
    end else begin
      mag = mx - my;
      sg  = x[N-1];
    end
    if (mag == 0) sg = 1'b0;
    mm = mag[M-1:0];
    return {ov, sg, mm};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || s !== '0 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: out_valid=%b s=%b ovf=%b in_ready=%b, want 0 0000 0 1",
               out_valid, s, ovf, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] va [7];
    logic [N-1:0] vb [7];
    logic [N:0]   exp;
    va = '{4'b0011, 4'b1011, 4'b0110, 4'b0011, 4'b1000, 4'b0101, 4'b1111};
    vb = '{4'b0010, 4'b0101, 4'b1010, 4'b1011, 4'b1000, 4'b0100, 4'b1001};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      in_valid  = 1'b1;
      a         = va[i];
      b         = vb[i];
      out_ready = 1'b1;
      exp       = model(va[i], vb[i]);
      @(posedge clk); #1;  // operand accepted at this edge
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir_early[%0d]: out_valid=%b want 0", i, out_valid);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || {ovf, s} !== exp) begin
        n_err++;
        $display("FAIL dir_result[%0d] a=%b b=%b: out_valid=%b ovf=%b s=%b, want 1 %b %b",
                 i, va[i], vb[i], out_valid, ovf, s, exp[N], exp[N-1:0]);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL dir_single_beat[%0d]: out_valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_random();
    logic [N:0] q[$];
    logic [N:0] exp;
    logic [N:0] held;
    logic       held_v;
    logic       fired;
    held_v   = 1'b0;
    held     = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (held_v) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {ovf, s} !== held) begin
          n_err++;
          $display("FAIL rand_hold cyc%0d: out_valid=%b ovf/s=%b, want 1 %b",
                   cyc, out_valid, {ovf, s}, held);
        end
      end
      held_v = out_valid && !out_ready;
      held   = {ovf, s};
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious cyc%0d: result %b with nothing expected", cyc, {ovf, s});
        end else begin
          exp = q.pop_front();
          if ({ovf, s} !== exp) begin
            n_err++;
            $display("FAIL rand_result cyc%0d: ovf/s=%b want %b", cyc, {ovf, s}, exp);
          end
        end
      end
      fired = in_valid && in_ready;
      if (fired) q.push_back(model(a, b));
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a        = N'($urandom);
        b        = N'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && q.size() != 0; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = q.pop_front();
        n_cmp++;
        if ({ovf, s} !== exp) begin
          n_err++;
          $display("FAIL rand_drain: ovf/s=%b want %b", {ovf, s}, exp);
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rand_lost: %0d results outstanding, want 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] pa [4];
    logic [N-1:0] pb [4];
    logic [N:0]   exp;
    int idx, acc, got, first_cyc, last_cyc;
    logic fired;
    for (int i = 0; i < 4; i++) begin
      pa[i] = N'($urandom);
      pb[i] = N'($urandom);
    end
    idx = 0; acc = 0; got = 0; first_cyc = 0; last_cyc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = pa[0];
    b = pb[0];
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      if (fired) begin
        acc++;
        idx++;
      end
      @(posedge clk); #1;
      if (fired) begin
        a = pa[idx];
        b = pb[idx];
      end
    end
    exp = model(pa[0], pb[0]);
    n_cmp++;
    if (acc != 2 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accepts: accepted=%0d in_ready=%b, want 2 0", acc, in_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || {ovf, s} !== exp) begin
      n_err++;
      $display("FAIL bp_hold: out_valid=%b ovf/s=%b, want 1 %b", out_valid, {ovf, s}, exp);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 12 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        exp = model(pa[got], pb[got]);
        n_cmp++;
        if ({ovf, s} !== exp) begin
          n_err++;
          $display("FAIL bp_order[%0d]: ovf/s=%b want %b", got, {ovf, s}, exp);
        end
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      fired = in_valid && in_ready;
      if (fired) idx++;
      @(posedge clk); #1;
      if (fired) begin
        if (idx < 4) begin
          a = pa[idx];
          b = pb[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_cmp++;
    if (got != 4 || last_cyc - first_cyc != 3) begin
      n_err++;
      $display("FAIL bp_rate: results=%0d span=%0d cycles, want 4 3", got, last_cyc - first_cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_extra: out_valid=%b in_valid=%b, want 0 0", out_valid, in_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    logic [N:0] exp;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = N'($urandom);
    b = N'($urandom);
    @(posedge clk); #1;
    a = N'($urandom);
    b = N'($urandom);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_setup: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || s !== '0 || ovf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: out_valid=%b s=%b ovf=%b, want 0 0000 0", out_valid, s, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_in_ready: in_ready=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b1;
    a = N'($urandom);
    b = N'($urandom);
    exp = model(a, b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_replay: out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b1 || {ovf, s} !== exp) begin
      n_err++;
      $display("FAIL mid_new: out_valid=%b ovf/s=%b, want 1 %b", out_valid, {ovf, s}, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
